gb_bus_ctrl: RTL and testbench
==============================

// Module: gb_bus_ctrl
// PURPOSE
//  Sequences the cartridge data-bus pads (bidir_pad, WIDTH=8) for the Game Boy edge connector.
//  - Synchronises the host RD/WR/CS strobes and decodes selection.
//  - Issues one memory request per bus cycle over a req/ack handshake.
//  - Drives read data with controlled output enable and turnaround; captures write data.
//  Sits between the pad wrappers and the ROM/RAM backing-store arbiter.
// PARAMETERS
//  DW          8   data bus width; matches bidir_pad WIDTH
//  AW          16  address bus width
//  ADDR_SETTLE 2   cycles the address must be stable after RD detect, before mem_req is raised
//  TURN_CYC    2   cycles pad_oe is held low after a read, before a new cycle is accepted
//  CNT_W       4   width of the shared settle/turn counter; must hold max(ADDR_SETTLE,TURN_CYC)
// PORTS
//  clk        in   1   system clock; same clock drives the bidir_pad registers
//  rst_n      in   1   asynchronous active-low reset
//  bus_addr   in   AW  host address, raw from the input pads
//  bus_rd_n   in   1   host read strobe, raw/asynchronous
//  bus_wr_n   in   1   host write strobe, raw/asynchronous
//  bus_cs_n   in   1   host RAM chip select, raw/asynchronous
//  pad_d_out  in   DW  registered pad input (bidir_pad d_out)
//  pad_d_in   out  DW  data to drive (bidir_pad d_in)
//  pad_oe     out  DW  per-bit output enable (bidir_pad oe); all bits always equal
//  mem_req    out  1   memory request; held high until mem_ack
//  mem_we     out  1   1 = write, 0 = read; valid while mem_req is high
//  mem_addr   out  AW  latched address; valid while mem_req is high
//  mem_wdata  out  DW  latched write data; valid while mem_req is high
//  mem_ack    in   1   single-cycle acknowledge; mem_rdata is valid in the same cycle
//  mem_rdata  in   DW  read data
//  busy       out  1   high whenever the state is not IDLE
//  err_late   out  1   1-cycle pulse: read ended before ack, or a cycle was lost during WR_REQ
// BEHAVIOUR
//  Reset:
//  - All outputs are 0 and the state is IDLE.
//  - Asserting rst_n low mid-operation drops pad_oe and mem_req immediately. The memory side must tolerate an abandoned request.
//  Synchronisation:
//  - rd_s, wr_s and cs_s are 2-FF synchronised copies of the strobes; all decisions use only these.
//  - sel = ~bus_addr[AW-1] | ~cs_s, i.e. ROM half, or RAM with CS asserted.
//  - bus_addr is sampled only when SETTLE ends.
//  State machine:
//  - IDLE: ~rd_s & sel -> SETTLE with cnt=ADDR_SETTLE-1. Else wr_s falling & sel -> WR_WAIT. rd has priority when both strobes are low.
//  - SETTLE: if rd_s goes high -> IDLE (abort, no request). At cnt==0: latch mem_addr, mem_req=1, mem_we=0, go to RD_REQ.
//  - RD_REQ: mem_req is held until mem_ack.
//      - On ack with rd_s still low: pad_d_in<=mem_rdata, pad_oe<='1, go to RD_DRIVE.
//      - On ack with rd_s already high: no drive, err_late pulse, go to TURN.
//  - RD_DRIVE: data and OE are held. When rd_s goes high or sel drops: pad_oe<=0, cnt=TURN_CYC-1, go to TURN.
//  - TURN: count down, then go to IDLE. Strobes are ignored during TURN.
//  - WR_WAIT: mem_wdata<=pad_d_out every cycle while wr_s is low, so the last value before the edge is kept.
//      - On wr_s rising: latch mem_addr, mem_req=1, mem_we=1, go to WR_REQ.
//      - If sel drops while wr_s is low: go to IDLE.
//  - WR_REQ: hold the request until mem_ack, then go to IDLE. A wr_s falling edge in this state is lost and raises an err_late pulse.
//  Timing:
//  - pad_oe and pad_d_in are registered here and registered again in the pad, giving 2 cycles from decision to pin.
//  - RD detect to pin drive is 2 (sync) + ADDR_SETTLE + ack latency + 2 cycles.
//  Safety:
//  - pad_oe is forced to 0 whenever wr_s is low, regardless of state.
//  - pad_oe is never high outside RD_DRIVE.
//  Counter: cnt is CNT_W bits, decrements and saturates at 0. A parameter value of 0 is treated as 1.
// STRUCTURE
//  - Package gb_bus_pkg holds the state enum (IDLE, SETTLE, RD_REQ, RD_DRIVE, TURN, WR_WAIT, WR_REQ) and the ROM/RAM decode constants.
//  - One sub-module, sync_ff2 (parameterised width, async active-low reset to 1), synchronises {rd_n, wr_n, cs_n}.
//  - The FSM, counter and datapath registers live here.
// TESTING
//  1. Read ROM: addr=0x0150, rd_n low 30 cycles, ack 3 cycles after req with rdata=0xC3.
//     -> mem_addr=0x0150, mem_we=0, pad_d_in=0xC3.
//     -> pad_oe high until 2-3 cycles after rd_n rises, then low for TURN_CYC cycles.
//  2. Write RAM: addr=0xA000, cs_n low, wr_n low 10 cycles with pad_d_out=0x5A, then wr_n high.
//     -> one mem_req with mem_we=1, mem_addr=0xA000, mem_wdata=0x5A.
//     -> pad_oe stays 0 throughout.
//  3. Late ack: rd_n low 4 cycles, ack delayed 20 cycles.
//     -> pad_oe never rises, err_late pulses once, state is IDLE after TURN.
//  4. Unselected access: addr=0xA000, cs_n high, rd_n low.
//     -> no mem_req, busy stays 0, pad_oe stays 0.
//  5. SETTLE abort: rd_n low 2 cycles then high (glitch).
//     -> no mem_req, return to IDLE.
//  6. Reset mid-read: rst_n low while in RD_DRIVE.
//     -> pad_oe, mem_req and busy are 0 in the same cycle.
//     -> a full read after release behaves as in test 1.

Source files
------------

// File: rtl/gb_bus_pkg.sv
// Shared types and decode constants for the cartridge bus controller.
package gb_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        RD_REQ,
        RD_DRIVE,
        TURN,
        WR_WAIT,
        WR_REQ
    } state_t;

    // Address MSB value that selects the ROM half of the map
    localparam logic ROM_MSB = 1'b0;
    // Level of the synchronised RAM chip select when asserted
    localparam logic CS_ON   = 1'b0;

    // Counter load value for a cycle count; a count of 0 behaves like 1
    function automatic int cnt_load(input int cyc);
        return (cyc < 1) ? 0 : cyc - 1;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser; flops reset to 1 so idle-high strobes read inactive.
module sync_ff2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Metastability stage followed by the stable stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gb_bus_ctrl.sv
// Game Boy cartridge bus sequencer: strobe sync, select decode, req/ack
// memory handshake, read drive with turnaround and write data capture.
module gb_bus_ctrl
    import gb_bus_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 16,
    parameter int ADDR_SETTLE = 2,
    parameter int TURN_CYC    = 2,
    parameter int CNT_W       = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_bus_addr,
    input  logic          i_bus_rd_n,
    input  logic          i_bus_wr_n,
    input  logic          i_bus_cs_n,
    input  logic [DW-1:0] i_pad_d_out,
    output logic [DW-1:0] o_pad_d_in,
    output logic [DW-1:0] o_pad_oe,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ack,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy,
    output logic          o_err_late
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(cnt_load(ADDR_SETTLE));
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(cnt_load(TURN_CYC));

    logic [2:0]       w_sync;
    logic             w_rd_s, w_wr_s, w_cs_s, w_sel, w_wr_fall;
    logic [CNT_W-1:0] w_cnt_dec;

    state_t           r_state, w_nxt_state;
    logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
    logic             r_wr_d;
    logic             r_mem_req, w_nxt_req;
    logic             r_mem_we, w_nxt_we;
    logic [AW-1:0]    r_mem_addr, w_nxt_addr;
    logic [DW-1:0]    r_mem_wdata, w_nxt_wdata;
    logic [DW-1:0]    r_pad_d_in, w_nxt_din;
    logic             r_pad_oe, w_nxt_oe;
    logic             r_err_late, w_nxt_err;

    sync_ff2 #(.W(3)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     ({i_bus_rd_n, i_bus_wr_n, i_bus_cs_n}),
        .o_q     (w_sync)
    );

    assign w_rd_s    = w_sync[2];
    assign w_wr_s    = w_sync[1];
    assign w_cs_s    = w_sync[0];
    assign w_sel     = (i_bus_addr[AW-1] == ROM_MSB) | (w_cs_s == CS_ON);
    assign w_wr_fall = r_wr_d & ~w_wr_s;
    assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;

    // Next-state and datapath decisions; every register holds by default
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_req   = r_mem_req;
        w_nxt_we    = r_mem_we;
        w_nxt_addr  = r_mem_addr;
        w_nxt_wdata = r_mem_wdata;
        w_nxt_din   = r_pad_d_in;
        w_nxt_oe    = r_pad_oe;
        w_nxt_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rd_s && w_sel) begin
                    w_nxt_state = SETTLE;
                    w_nxt_cnt   = SETTLE_LD;
                end else if (w_wr_fall && w_sel) begin
                    w_nxt_state = WR_WAIT;
                end
            end
            SETTLE: begin
                if (w_rd_s) begin
                    w_nxt_state = IDLE;
                end else if (r_cnt == '0) begin
                    w_nxt_addr  = i_bus_addr;
                    w_nxt_req   = 1'b1;
                    w_nxt_we    = 1'b0;
                    w_nxt_state = RD_REQ;
                end else begin
                    w_nxt_cnt = w_cnt_dec;
                end
            end
            RD_REQ: begin
                if (i_mem_ack) begin
                    w_nxt_req = 1'b0;
                    if (!w_rd_s) begin
                        w_nxt_din   = i_mem_rdata;
                        w_nxt_oe    = 1'b1;
                        w_nxt_state = RD_DRIVE;
                    end else begin
                        // Host gave up before the data came back
                        w_nxt_err   = 1'b1;
                        w_nxt_cnt   = TURN_LD;
                        w_nxt_state = TURN;
                    end
                end
            end
            RD_DRIVE: begin
                if (w_rd_s || !w_sel) begin
                    w_nxt_oe    = 1'b0;
                    w_nxt_cnt   = TURN_LD;
                    w_nxt_state = TURN;
                end
            end
            TURN: begin
                if (r_cnt == '0) w_nxt_state = IDLE;
                else             w_nxt_cnt   = w_cnt_dec;
            end
            WR_WAIT: begin
                if (w_wr_s) begin
                    w_nxt_addr  = i_bus_addr;
                    w_nxt_req   = 1'b1;
                    w_nxt_we    = 1'b1;
                    w_nxt_state = WR_REQ;
                end else begin
                    // Keep tracking the bus so the last value before the edge wins
                    w_nxt_wdata = i_pad_d_out;
                    if (!w_sel) w_nxt_state = IDLE;
                end
            end
            WR_REQ: begin
                if (w_wr_fall) w_nxt_err = 1'b1;
                if (i_mem_ack) begin
                    w_nxt_req   = 1'b0;
                    w_nxt_we    = 1'b0;
                    w_nxt_state = IDLE;
                end
            end
            default: begin
                w_nxt_oe    = 1'b0;
                w_nxt_req   = 1'b0;
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State, counter and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wr_d      <= 1'b1;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_pad_d_in  <= '0;
            r_pad_oe    <= 1'b0;
            r_err_late  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_wr_d      <= w_wr_s;
            r_mem_req   <= w_nxt_req;
            r_mem_we    <= w_nxt_we;
            r_mem_addr  <= w_nxt_addr;
            r_mem_wdata <= w_nxt_wdata;
            r_pad_d_in  <= w_nxt_din;
            r_pad_oe    <= w_nxt_oe;
            r_err_late  <= w_nxt_err;
        end
    end

    // Never fight the host: a low write strobe kills the drive in any state
    assign o_pad_oe    = {DW{r_pad_oe & w_wr_s}};
    assign o_pad_d_in  = r_pad_d_in;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state != IDLE);
    assign o_err_late  = r_err_late;

endmodule

// File: tb/tb_gb_bus_ctrl.sv
// Directed bench for gb_bus_ctrl: ROM read, RAM write, late ack,
// unselected access, settle abort and reset during a read.
module tb_gb_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_addr;
    logic        bus_rd_n, bus_wr_n, bus_cs_n;
    logic [7:0]  pad_d_out, pad_d_in, pad_oe;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy, err_late;

    int checks   = 0;
    int failures = 0;

    int         ack_dly  = 3;
    logic [7:0] ack_data = 8'hC3;

    int          req_rises   = 0;
    int          oe_cycles   = 0;
    int          err_pulses  = 0;
    int          busy_cycles = 0;
    logic        prev_req    = 1'b0;
    logic [15:0] cap_addr    = 16'h0;
    logic        cap_we      = 1'b0;
    logic [7:0]  cap_wdata   = 8'h0;

    always #5 clk = ~clk;

    gb_bus_ctrl u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_bus_addr  (bus_addr),
        .i_bus_rd_n  (bus_rd_n),
        .i_bus_wr_n  (bus_wr_n),
        .i_bus_cs_n  (bus_cs_n),
        .i_pad_d_out (pad_d_out),
        .o_pad_d_in  (pad_d_in),
        .o_pad_oe    (pad_oe),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_busy      (busy),
        .o_err_late  (err_late)
    );

    // Memory model: ack ack_dly cycles after the request rises
    initial begin
        int wait_cnt;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_ack) begin
                wait_cnt++;
                if (wait_cnt >= ack_dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = ack_data;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Event monitor
    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            req_rises <= req_rises + 1;
            cap_addr  <= mem_addr;
            cap_we    <= mem_we;
            cap_wdata <= mem_wdata;
        end
        prev_req <= mem_req;
        if (pad_oe != 8'h00) oe_cycles   <= oe_cycles + 1;
        if (err_late)        err_pulses  <= err_pulses + 1;
        if (busy)            busy_cycles <= busy_cycles + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full read transaction; reports what the pads did
    task automatic do_read(input logic [15:0] a, input int low_cyc,
                           output int first_oe, output int hold,
                           output int turn, output logic [7:0] din);
        first_oe = -1; hold = 0; turn = 0; din = 8'h00;
        bus_addr = a; bus_cs_n = 1'b1; bus_rd_n = 1'b0;
        for (int i = 1; i <= low_cyc; i++) begin
            @(negedge clk);
            if (pad_oe != 8'h00 && first_oe < 0) begin
                first_oe = i;
                din      = pad_d_in;
            end
        end
        bus_rd_n = 1'b1;
        for (int i = 0; i < 10 && pad_oe != 8'h00; i++) begin
            @(negedge clk);
            if (pad_oe != 8'h00) hold++;
        end
        for (int i = 0; i < 10 && busy; i++) begin
            turn++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus_addr = 16'h0000; bus_rd_n = 1'b1; bus_wr_n = 1'b1;
        bus_cs_n = 1'b1; pad_d_out = 8'h00;
        tick(3);
        checks++;
        if ({pad_oe, pad_d_in, mem_wdata} !== 24'h0) begin
            failures++; $display("FAIL rst_data got=%h exp=0", {pad_oe, pad_d_in, mem_wdata});
        end
        checks++;
        if ({mem_req, mem_we, busy, err_late} !== 4'b0) begin
            failures++; $display("FAIL rst_ctrl got=%b exp=0000", {mem_req, mem_we, busy, err_late});
        end
        checks++;
        if (mem_addr !== 16'h0) begin
            failures++; $display("FAIL rst_addr got=%h exp=0000", mem_addr);
        end
        rst_n = 1'b1;
        tick(3);
        checks++;
        if ({busy, mem_req, pad_oe} !== 10'h0) begin
            failures++; $display("FAIL rst_idle got=%h exp=0", {busy, mem_req, pad_oe});
        end
    endtask

    task automatic test_read_rom();
        int f, h, t, r0, e0; logic [7:0] d;
        r0 = req_rises; e0 = err_pulses;
        ack_dly = 3; ack_data = 8'hC3;
        do_read(16'h0150, 30, f, h, t, d);
        tick(2);
        checks++;
        if (req_rises - r0 != 1) begin failures++; $display("FAIL rd_reqs got=%0d exp=1", req_rises - r0); end
        checks++;
        if (cap_addr !== 16'h0150) begin failures++; $display("FAIL rd_addr got=%h exp=0150", cap_addr); end
        checks++;
        if (cap_we !== 1'b0) begin failures++; $display("FAIL rd_we got=%b exp=0", cap_we); end
        checks++;
        if (d !== 8'hC3) begin failures++; $display("FAIL rd_data got=%h exp=c3", d); end
        checks++;
        if (f != 8) begin failures++; $display("FAIL rd_latency got=%0d exp=8", f); end
        checks++;
        if (h < 2 || h > 3) begin failures++; $display("FAIL rd_oe_hold got=%0d exp=2..3", h); end
        checks++;
        if (t != 2) begin failures++; $display("FAIL rd_turn got=%0d exp=2", t); end
        checks++;
        if (err_pulses != e0) begin failures++; $display("FAIL rd_err got=%0d exp=0", err_pulses - e0); end
    endtask

    task automatic test_write_ram();
        int r0, o0, e0;
        r0 = req_rises; o0 = oe_cycles; e0 = err_pulses;
        ack_dly = 2;
        bus_addr = 16'hA000; bus_cs_n = 1'b0; pad_d_out = 8'h5A; bus_wr_n = 1'b0;
        tick(10);
        bus_wr_n = 1'b1;
        tick(12);
        bus_cs_n = 1'b1; pad_d_out = 8'h00;
        tick(2);
        checks++;
        if (req_rises - r0 != 1) begin failures++; $display("FAIL wr_reqs got=%0d exp=1", req_rises - r0); end
        checks++;
        if (cap_we !== 1'b1) begin failures++; $display("FAIL wr_we got=%b exp=1", cap_we); end
        checks++;
        if (cap_addr !== 16'hA000) begin failures++; $display("FAIL wr_addr got=%h exp=a000", cap_addr); end
        checks++;
        if (cap_wdata !== 8'h5A) begin failures++; $display("FAIL wr_wdata got=%h exp=5a", cap_wdata); end
        checks++;
        if (oe_cycles != o0) begin failures++; $display("FAIL wr_oe got=%0d exp=0", oe_cycles - o0); end
        checks++;
        if (busy !== 1'b0 || err_pulses != e0) begin
            failures++; $display("FAIL wr_end got=%b/%0d exp=0/0", busy, err_pulses - e0);
        end
    endtask

    task automatic test_late_ack();
        int r0, o0, e0;
        r0 = req_rises; o0 = oe_cycles; e0 = err_pulses;
        ack_dly = 20;
        bus_addr = 16'h0200; bus_cs_n = 1'b1; bus_rd_n = 1'b0;
        tick(4);
        bus_rd_n = 1'b1;
        for (int i = 0; i < 60 && busy; i++) tick(1);
        tick(1);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL late_idle got=%b exp=0", busy); end
        checks++;
        if (err_pulses - e0 != 1) begin failures++; $display("FAIL late_err got=%0d exp=1", err_pulses - e0); end
        checks++;
        if (oe_cycles != o0) begin failures++; $display("FAIL late_oe got=%0d exp=0", oe_cycles - o0); end
        checks++;
        if (req_rises - r0 != 1 || mem_req !== 1'b0) begin
            failures++; $display("FAIL late_req got=%0d/%b exp=1/0", req_rises - r0, mem_req);
        end
        ack_dly = 3;
    endtask

    task automatic test_unselected();
        int r0, o0, b0;
        r0 = req_rises; o0 = oe_cycles; b0 = busy_cycles;
        bus_addr = 16'hA000; bus_cs_n = 1'b1; bus_rd_n = 1'b0;
        tick(15);
        bus_rd_n = 1'b1;
        tick(4);
        checks++;
        if (req_rises != r0) begin failures++; $display("FAIL unsel_req got=%0d exp=0", req_rises - r0); end
        checks++;
        if (busy_cycles != b0) begin failures++; $display("FAIL unsel_busy got=%0d exp=0", busy_cycles - b0); end
        checks++;
        if (oe_cycles != o0) begin failures++; $display("FAIL unsel_oe got=%0d exp=0", oe_cycles - o0); end
    endtask

    task automatic test_settle_abort();
        int r0, b0;
        r0 = req_rises; b0 = busy_cycles;
        bus_addr = 16'h0100; bus_cs_n = 1'b1; bus_rd_n = 1'b0;
        tick(2);
        bus_rd_n = 1'b1;
        tick(8);
        checks++;
        if (req_rises != r0) begin failures++; $display("FAIL abort_req got=%0d exp=0", req_rises - r0); end
        checks++;
        if (busy_cycles == b0) begin failures++; $display("FAIL abort_entered got=0 exp=>0"); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_read();
        int f, h, t; logic [7:0] d; bit reached;
        ack_dly = 3; ack_data = 8'hC3; reached = 0;
        bus_addr = 16'h0150; bus_cs_n = 1'b1; bus_rd_n = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            tick(1);
            if (pad_oe != 8'h00) reached = 1;
        end
        checks++;
        if (!reached) begin failures++; $display("FAIL mid_drive got=0 exp=1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pad_oe, mem_req, busy} !== 10'h0) begin
            failures++; $display("FAIL mid_rst_out got=%h exp=0", {pad_oe, mem_req, busy});
        end
        bus_rd_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        do_read(16'h0150, 30, f, h, t, d);
        tick(2);
        checks++;
        if (d !== 8'hC3 || cap_addr !== 16'h0150 || cap_we !== 1'b0) begin
            failures++; $display("FAIL mid_reread got=%h/%h/%b exp=c3/0150/0", d, cap_addr, cap_we);
        end
        checks++;
        if (f != 8) begin failures++; $display("FAIL mid_latency got=%0d exp=8", f); end
        checks++;
        if (h < 2 || h > 3 || t != 2) begin
            failures++; $display("FAIL mid_turn got=%0d/%0d exp=2..3/2", h, t);
        end
    endtask

    initial begin
        test_reset();
        test_read_rom();
        test_write_ram();
        test_late_ack();
        test_unselected();
        test_settle_abort();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
